board_streamer: RTL

- Reads the 405-bit packed sudoku board (81 cells × 5 bits) plus cursor and error state driven by the game core.
- Serialises them into a cell-per-beat stream over a valid/ready handshake, for the display/VGA tile renderer.
- Snapshots the whole board at frame start, so a frame is always self-consistent even if the game updates mid-stream.
- Sits between the sudoku core outputs and the display path.

---
 rtl/board_streamer_if.sv | 24 ++
 rtl/board_streamer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/board_streamer_if.sv
// board_streamer_if: cell-per-beat valid/ready stream from the board streamer to the tile renderer.
interface board_streamer_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_row;
  logic [3:0] out_col;
  logic [3:0] out_value;
  logic       out_locked;
  logic       out_cursor;
  logic       out_error;
  logic       out_bad;
  logic       out_sop;
  logic       out_eop;
  modport master (
    output out_valid, out_row, out_col, out_value, out_locked, out_cursor,
           out_error, out_bad, out_sop, out_eop,
    input  out_ready
  );
  modport slave (
    input  out_valid, out_row, out_col, out_value, out_locked, out_cursor,
           out_error, out_bad, out_sop, out_eop,
    output out_ready
  );
endinterface

// File: rtl/board_streamer.sv
// board_streamer: snapshots the packed sudoku board and streams it cell-per-beat over valid/ready.
// Define BOARD_STREAMER_CHECKSUM_EN to append an XOR-checksum trailer beat after cell 80.
module board_streamer #(
  parameter int CELLS  = 81,
  parameter int CELL_W = 5,
  parameter int GRID_N = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CELLS*CELL_W-1:0] board,
  input  logic [3:0]              cursor_x,
  input  logic [3:0]              cursor_y,
  input  logic                    error,
  input  logic                    frame_req,
  output logic                    busy,
  output logic                    frame_done,
  board_streamer_if.master        st
);
  localparam int IW = $clog2(CELLS + 1);
`ifdef BOARD_STREAMER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_TRAILER, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;
`endif
  state_t                  r_state, w_next;
  logic [CELLS*CELL_W-1:0] r_board;
  logic [3:0]              r_cx, r_cy, r_row, r_col;
  logic                    r_err;
  logic [IW-1:0]           r_idx;
  logic                    w_last;
`ifdef BOARD_STREAMER_CHECKSUM_EN
  logic [3:0]              r_csum;
`endif
  assign w_last = r_idx == IW'(CELLS - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next        = r_state;
    busy          = 1'b0;
    frame_done    = 1'b0;
    st.out_valid  = 1'b0;
    st.out_row    = 4'd0;
    st.out_col    = 4'd0;
    st.out_value  = 4'd0;
    st.out_locked = 1'b0;
    st.out_cursor = 1'b0;
    st.out_error  = 1'b0;
    st.out_bad    = 1'b0;
    st.out_sop    = 1'b0;
    st.out_eop    = 1'b0;
    case (r_state)
      S_IDLE: w_next = frame_req ? S_STREAM : S_IDLE;
      S_STREAM: begin
        busy          = 1'b1;
        st.out_valid  = 1'b1;
        st.out_row    = r_row;
        st.out_col    = r_col;
        st.out_value  = r_board[3:0];
        st.out_locked = r_board[4];
        st.out_cursor = r_row == r_cy && r_col == r_cx;
        st.out_error  = r_err;
        st.out_bad    = r_board[3:0] > 4'd9;
        st.out_sop    = r_idx == '0;
`ifdef BOARD_STREAMER_CHECKSUM_EN
        w_next        = st.out_ready && w_last ? S_TRAILER : S_STREAM;
`else
        st.out_eop    = w_last;
        w_next        = st.out_ready && w_last ? S_DONE : S_STREAM;
`endif
      end
`ifdef BOARD_STREAMER_CHECKSUM_EN
      S_TRAILER: begin
        busy         = 1'b1;
        st.out_valid = 1'b1;
        st.out_row   = 4'hf;
        st.out_col   = 4'hf;
        st.out_value = r_csum;
        st.out_error = r_err;
        st.out_eop   = 1'b1;
        w_next       = st.out_ready ? S_DONE : S_TRAILER;
      end
`endif
      S_DONE: begin
        frame_done = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
  // The snapshot shifts down one cell per accept, so the current cell always sits in the low bits.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_board <= '0;
      r_cx    <= 4'd0;
      r_cy    <= 4'd0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_row   <= 4'd0;
      r_col   <= 4'd0;
`ifdef BOARD_STREAMER_CHECKSUM_EN
      r_csum  <= 4'd0;
`endif
    end else if (r_state == S_IDLE && frame_req) begin
      r_board <= board;
      r_cx    <= cursor_x;
      r_cy    <= cursor_y;
      r_err   <= error;
      r_idx   <= '0;
      r_row   <= 4'd0;
      r_col   <= 4'd0;
`ifdef BOARD_STREAMER_CHECKSUM_EN
      r_csum  <= 4'd0;
`endif
    end else if (r_state == S_STREAM && st.out_ready) begin
      r_board <= r_board >> CELL_W;
      r_idx   <= r_idx + IW'(1);
      r_col   <= r_col == 4'(GRID_N - 1) ? 4'd0 : r_col + 4'd1;
      r_row   <= r_col == 4'(GRID_N - 1) ? r_row + 4'd1 : r_row;
`ifdef BOARD_STREAMER_CHECKSUM_EN
      r_csum  <= r_csum ^ r_board[3:0];
`endif
    end
endmodule
